// File: rtl/uart_rx_ctrl_pkg.sv
// Shared state encoding and sizing constants for the UART receive controller.
package uart_rx_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int unsigned DEFAULT_DEPTH     = 4;
   localparam int unsigned DEFAULT_DIV_WIDTH = 16;
   localparam int unsigned ERR_CNT_WIDTH     = 8;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with power-of-2 depth; a push into a full FIFO is accepted only when a pop
// retires the head in the same cycle.
module uart_byte_fifo #(
   parameter int unsigned Depth = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic [7:0] data_i,
   output logic [7:0] head_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth) + 1;

   logic [7:0]      mem_q [Depth];
   logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CntW'(Depth));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = empty_o ? '0 : mem_q[rd_q];

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + PtrW'(1);
      if (do_pop)  rd_d = rd_q + PtrW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage carries no reset: emptiness is tracked by cnt_q and head_o is masked when empty.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversample tick generation, byte FIFO and sticky status.
// Define UART_RX_CTRL_ERRCNT_EN to add the saturating errCount output.
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int unsigned Depth    = DEFAULT_DEPTH,
   parameter int unsigned DivWidth = DEFAULT_DIV_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [DivWidth-1:0]      clkDiv,
   output logic                     rxEn,
   input  logic [7:0]               rxData,
   input  logic                     rxDone,
   input  logic                     rxErr,
   output logic [7:0]               outData,
   output logic                     outValid,
   input  logic                     outReady,
   output logic                     overflow,
   output logic                     frameErr,
`ifdef UART_RX_CTRL_ERRCNT_EN
   output logic [ERR_CNT_WIDTH-1:0] errCount,
`endif
   input  logic                     errClear,
   output logic                     busy
);

   state_e              state_q, state_d;
   logic [DivWidth-1:0] div_q, div_d;
   logic                ovf_q, ovf_d;
   logic                ferr_q, ferr_d;
   logic                fifo_full, fifo_empty;
   logic                push, pop, err_ev;

   assign rxEn     = (state_q == ST_RUN) && (div_q == '0);
   assign push     = rxEn && rxDone && !rxErr;
   assign err_ev   = rxEn && rxErr;
   assign pop      = outValid && outReady;
   assign outValid = !fifo_empty;
   assign busy     = (state_q != ST_OFF);
   assign overflow = ovf_q;
   assign frameErr = ferr_q;

   uart_byte_fifo #(
      .Depth(Depth)
   ) u_fifo (
      .clk_i  (clk),
      .rst_i  (reset),
      .push_i (push),
      .pop_i  (pop),
      .data_i (rxData),
      .head_o (outData),
      .full_o (fifo_full),
      .empty_o(fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OFF:   if (enable) state_d = ST_RUN;
         ST_RUN:   if (!enable) state_d = fifo_empty ? ST_OFF : ST_DRAIN;
         ST_DRAIN: begin
            if (enable)          state_d = ST_RUN;
            else if (fifo_empty) state_d = ST_OFF;
         end
         default:  state_d = ST_OFF;
      endcase
   end

   // clkDiv is sampled only on entry to RUN and on each terminal-count reload.
   always_comb begin
      div_d = div_q;
      if (state_q != ST_RUN && state_d == ST_RUN) div_d = clkDiv;
      else if (state_q == ST_RUN)                 div_d = (div_q == '0) ? clkDiv : div_q - DivWidth'(1);
   end

   always_comb begin
      ovf_d  = ovf_q;
      ferr_d = ferr_q;
      if (errClear) begin
         ovf_d  = 1'b0;
         ferr_d = 1'b0;
      end
      if (push && fifo_full && !pop) ovf_d = 1'b1;
      if (err_ev)                    ferr_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_OFF;
         div_q   <= '0;
         ovf_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         ovf_q   <= ovf_d;
         ferr_q  <= ferr_d;
      end
   end

`ifdef UART_RX_CTRL_ERRCNT_EN
   logic [ERR_CNT_WIDTH-1:0] ecnt_q, ecnt_d;

   always_comb begin
      ecnt_d = ecnt_q;
      if (err_ev) begin
         if (ecnt_q != '1) ecnt_d = ecnt_q + ERR_CNT_WIDTH'(1);
      end else if (errClear) begin
         ecnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ecnt_q <= '0;
      else       ecnt_q <= ecnt_d;
   end

   assign errCount = ecnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus queues expected bytes, a monitor checks each pop.
module tb_uart_rx_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] clkDiv = '0;
   logic        rxEn;
   logic [7:0]  rxData = '0;
   logic        rxDone = 1'b0;
   logic        rxErr = 1'b0;
   logic [7:0]  outData;
   logic        outValid;
   logic        outReady = 1'b0;
   logic        overflow;
   logic        frameErr;
   logic        errClear = 1'b0;
   logic        busy;
`ifdef UART_RX_CTRL_ERRCNT_EN
   logic [7:0]  errCount;
`endif

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   uart_rx_ctrl #(
      .Depth(4),
      .DivWidth(16)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .clkDiv  (clkDiv),
      .rxEn    (rxEn),
      .rxData  (rxData),
      .rxDone  (rxDone),
      .rxErr   (rxErr),
      .outData (outData),
      .outValid(outValid),
      .outReady(outReady),
      .overflow(overflow),
      .frameErr(frameErr),
`ifdef UART_RX_CTRL_ERRCNT_EN
      .errCount(errCount),
`endif
      .errClear(errClear),
      .busy    (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b, input bit expect_ok);
      int unsigned waited = 0;
      while (!rxEn && waited < 20) begin
         step();
         waited++;
      end
      if (!rxEn) chk("push_rxen_wait", 32'(rxEn), 32'd1);
      rxData = b;
      rxDone = 1'b1;
      if (expect_ok) exp_q.push_back(b);
      step();
      rxDone = 1'b0;
   endtask

   // Monitor: every accepted handshake must present the oldest expected byte.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!reset && outValid && outReady) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected actual=0x%0h expected=none", outData);
            end else begin
               e = exp_q.pop_front();
               chk("sb_data", 32'(outData), 32'(e));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      #1;
      chk("rst_outValid", 32'(outValid), 32'd0);
      chk("rst_outData",  32'(outData),  32'd0);
      chk("rst_rxEn",     32'(rxEn),     32'd0);
      chk("rst_busy",     32'(busy),     32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_frameErr", 32'(frameErr), 32'd0);
`ifdef UART_RX_CTRL_ERRCNT_EN
      chk("rst_errCount", 32'(errCount), 32'd0);
`endif
      step();
      step();
      reset = 1'b0;
      step();

      // Tick period clkDiv+1 = 4, first pulse on the fourth RUN cycle
      clkDiv = 16'd3;
      enable = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         chk("rxen_period", 32'(rxEn), 32'((k % 4) == 3));
      end
      chk("run_busy", 32'(busy), 32'd1);
      enable = 1'b0;
      step();
      chk("off_busy", 32'(busy), 32'd0);
      chk("off_rxEn", 32'(rxEn), 32'd0);

      // Single byte, 1-cycle latency, held until accepted
      clkDiv = 16'd0;
      enable = 1'b1;
      step();
      push_byte(8'hA5, 1'b1);
      chk("a5_valid", 32'(outValid), 32'd1);
      chk("a5_data",  32'(outData),  32'hA5);
      step();
      chk("a5_hold",  32'(outData),  32'hA5);
      outReady = 1'b1;
      step();
      chk("a5_popped", 32'(outValid), 32'd0);
      outReady = 1'b0;

      // Five pushes into a 4-deep FIFO: fifth dropped
      push_byte(8'h11, 1'b1);
      push_byte(8'h22, 1'b1);
      push_byte(8'h33, 1'b1);
      push_byte(8'h44, 1'b1);
      chk("full_no_ovf", 32'(overflow), 32'd0);
      push_byte(8'h55, 1'b0);
      chk("ovf_set",   32'(overflow), 32'd1);
      chk("ovf_head",  32'(outData),  32'h11);
      outReady = 1'b1;
      repeat (4) step();
      chk("ovf_drained", 32'(outValid), 32'd0);
      outReady = 1'b0;
      errClear = 1'b1;
      step();
      errClear = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);

      // Full FIFO with simultaneous push and pop: push accepted
      push_byte(8'h61, 1'b1);
      push_byte(8'h62, 1'b1);
      push_byte(8'h63, 1'b1);
      push_byte(8'h64, 1'b1);
      outReady = 1'b1;
      push_byte(8'h65, 1'b1);
      chk("pushpop_no_ovf", 32'(overflow), 32'd0);
      chk("pushpop_valid",  32'(outValid), 32'd1);
      repeat (4) step();
      chk("pushpop_drained", 32'(outValid), 32'd0);
      outReady = 1'b0;

      // Framing errors
      rxData = 8'h77;
      rxDone = 1'b1;
      rxErr  = 1'b1;
      step();
      rxDone = 1'b0;
      rxErr  = 1'b0;
      chk("ferr_set",     32'(frameErr), 32'd1);
      chk("ferr_no_push", 32'(outValid), 32'd0);
`ifdef UART_RX_CTRL_ERRCNT_EN
      chk("ecnt_one", 32'(errCount), 32'd1);
`endif
      errClear = 1'b1;
      rxErr    = 1'b1;
      step();
      rxErr    = 1'b0;
      chk("ferr_set_wins", 32'(frameErr), 32'd1);
`ifdef UART_RX_CTRL_ERRCNT_EN
      chk("ecnt_inc_wins", 32'(errCount), 32'd2);
`endif
      step();
      errClear = 1'b0;
      chk("ferr_cleared", 32'(frameErr), 32'd0);
      chk("ovf_still_0",  32'(overflow), 32'd0);
`ifdef UART_RX_CTRL_ERRCNT_EN
      chk("ecnt_cleared", 32'(errCount), 32'd0);
`endif
      enable = 1'b0;
      step();
      rxDone = 1'b1;
      rxErr  = 1'b1;
      step();
      rxDone = 1'b0;
      rxErr  = 1'b0;
      chk("unqual_rxEn",  32'(rxEn),     32'd0);
      chk("unqual_ferr",  32'(frameErr), 32'd0);
      chk("unqual_valid", 32'(outValid), 32'd0);
`ifdef UART_RX_CTRL_ERRCNT_EN
      chk("unqual_ecnt",  32'(errCount), 32'd0);
`endif

      // Drain after disable
      enable = 1'b1;
      step();
      push_byte(8'h81, 1'b1);
      push_byte(8'h82, 1'b1);
      enable = 1'b0;
      step();
      chk("drain_busy",  32'(busy),     32'd1);
      chk("drain_rxEn",  32'(rxEn),     32'd0);
      chk("drain_valid", 32'(outValid), 32'd1);
      outReady = 1'b1;
      step();
      step();
      chk("drain_empty", 32'(outValid), 32'd0);
      step();
      chk("drain_off",   32'(busy),     32'd0);
      outReady = 1'b0;

      // Asynchronous reset discards queued bytes at once
      enable = 1'b1;
      step();
      push_byte(8'h91, 1'b0);
      push_byte(8'h92, 1'b0);
      push_byte(8'h93, 1'b0);
      chk("pre_rst_valid", 32'(outValid), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_mid_valid", 32'(outValid), 32'd0);
      chk("rst_mid_busy",  32'(busy),     32'd0);
      chk("rst_mid_data",  32'(outData),  32'd0);
      enable = 1'b0;
      step();
      reset = 1'b0;

      // Empty FIFO ignores outReady; pointers stay aligned for the next byte
      outReady = 1'b1;
      enable   = 1'b1;
      repeat (3) step();
      chk("empty_ready_valid", 32'(outValid), 32'd0);
      push_byte(8'hC3, 1'b1);
      step();
      chk("post_rst_drained", 32'(outValid), 32'd0);
      outReady = 1'b0;
      enable   = 1'b0;
      repeat (3) step();

      chk("sb_all_consumed", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
